nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit add/subtract unit built on one 4-bit carry-in adder slice.

---
 rtl/alu_pkg.sv | 15 +
 rtl/nibble_add_ci.sv | 21 ++
 rtl/nibble_serial_adder.sv | 134 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, nibble width and add/sub opcodes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_add_ci.sv
// Combinational 4-bit adder slice with carry-in; also exposes the carry into bit 3.
module nibble_add_ci
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s4,
    output logic                co,
    output logic                c3
);

    logic [NIBBLE_W:0] total;

    assign total = {1'b0, a4} + {1'b0, b4} + {{NIBBLE_W{1'b0}}, ci};
    assign s4    = total[NIBBLE_W-1:0];
    assign co    = total[NIBBLE_W];
    // Sum bit 3 is a3^b3^c3, so the carry into the top bit falls out directly.
    assign c3    = s4[NIBBLE_W-1] ^ a4[NIBBLE_W-1] ^ b4[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit add/subtract unit with valid/ready handshakes.
// Define NIBBLE_SERIAL_ADDER_FLAGS_EN to compute the zero and overflow flags.
module nibble_serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;

    logic [NIBBLE_W-1:0] sliceA, sliceB, sliceSum;
    logic                sliceCo, sliceC3;
    logic                lastNibble;

    assign sliceA     = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    assign sliceB     = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    assign lastNibble = (idx_q == IDXW'(NIBBLES - 1));

    nibble_add_ci u_slice (
        .a4 (sliceA),
        .b4 (sliceB),
        .ci (carry_q),
        .s4 (sliceSum),
        .co (sliceCo),
        .c3 (sliceC3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and the carry flop seeded with sub.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = (sub == OP_SUB);
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = sliceSum;
                carry_d = sliceCo;
                idx_d   = idx_q + IDXW'(1);
                if (lastNibble) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_q;

`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    logic zero_q, ovf_q;

    // Flags are captured on the final RUN edge, alongside the top nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == RUN && lastNibble) begin
            zero_q <= (result_d == '0);
            ovf_q  <= sliceC3 ^ sliceCo;
        end
    end

    assign zero     = zero_q;
    assign overflow = ovf_q;
`else
    logic unusedC3;

    assign unusedC3 = sliceC3;
    assign zero     = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    int testsRun = 0;
    int testsFailed = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one operation; holdCycles > 0 stalls out_ready and pokes in_valid while DONE.
    task automatic applyStimulus(input string tag, input logic [15:0] opA, input logic [15:0] opB,
                                 input logic opSub, input logic [15:0] expRes, input logic expC,
                                 input logic expZ, input logic expV, input int holdCycles);
        int waitCnt;
        @(negedge clk);
        waitCnt = 0;
        while (!in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        a = opA;
        b = opB;
        sub = opSub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        sub = ~opSub;
        waitCnt = 0;
        while (!out_valid && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({tag, "/latency"}, 32'(waitCnt), 32'd4);
        checkOutput({tag, "/result"}, 32'(result), 32'(expRes));
        checkOutput({tag, "/carry"}, 32'(carry_out), 32'(expC));
        checkOutput({tag, "/zero"}, 32'(zero), 32'(expZ & FLAGS));
        checkOutput({tag, "/overflow"}, 32'(overflow), 32'(expV & FLAGS));
        checkOutput({tag, "/busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'b1;
            a = 16'h1111;
            b = 16'h2222;
            @(negedge clk);
            checkOutput({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "/hold_result"}, 32'(result), 32'(expRes));
            checkOutput({tag, "/hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "/drained"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "/idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] bbA [3];
        logic [15:0] bbB [3];
        logic        bbSub [3];
        logic [15:0] bbRes [3];
        int acceptCycle [3];
        int acceptIdx;
        int doneIdx;
        int cycle;

        #1;
        checkOutput("reset/in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset/out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset/result", 32'(result), 32'd0);
        checkOutput("reset/flags", {29'd0, carry_out, zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus("add_ovf_hold", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 5);
        applyStimulus("add_neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 0);

        // Abort during the second RUN cycle.
        @(negedge clk);
        a = 16'h1234;
        b = 16'h1111;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort/in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort/out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort/result", 32'(result), 32'd0);
        checkOutput("abort/flags", {29'd0, carry_out, zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort/ready_after", 32'(in_ready), 32'd1);
        applyStimulus("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back: accept, 4 RUN edges, 1 DONE edge, 1 IDLE cycle before the next accept.
        bbA[0] = 16'h0102; bbB[0] = 16'h0304; bbSub[0] = 1'b0; bbRes[0] = 16'h0406;
        bbA[1] = 16'hA000; bbB[1] = 16'h0001; bbSub[1] = 1'b1; bbRes[1] = 16'h9FFF;
        bbA[2] = 16'h00FF; bbB[2] = 16'h0F01; bbSub[2] = 1'b0; bbRes[2] = 16'h1000;
        acceptIdx = 0;
        doneIdx = 0;
        cycle = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (doneIdx < 3 && cycle < 100) begin
            if (out_valid) begin
                checkOutput($sformatf("b2b/result%0d", doneIdx), 32'(result), 32'(bbRes[doneIdx]));
                doneIdx++;
            end
            if (acceptIdx == 3) begin
                in_valid = 1'b0;
            end else if (in_ready) begin
                a = bbA[acceptIdx];
                b = bbB[acceptIdx];
                sub = bbSub[acceptIdx];
                in_valid = 1'b1;
                acceptCycle[acceptIdx] = cycle;
                acceptIdx++;
            end
            @(negedge clk);
            cycle++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b/completed", 32'(doneIdx), 32'd3);
        checkOutput("b2b/accepted", 32'(acceptIdx), 32'd3);
        if (acceptIdx == 3) begin
            checkOutput("b2b/spacing1", 32'(acceptCycle[1] - acceptCycle[0]), 32'd6);
            checkOutput("b2b/spacing2", 32'(acceptCycle[2] - acceptCycle[1]), 32'd6);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
